// File: rtl/ultrasonic_ranger.sv
// Round-robin multi-channel ultrasonic ranger: fires one sensor at a time, times the echo pulse,
// and keeps a per-channel near-obstacle flag with hysteresis.
module ultrasonic_ranger #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned WIDTH          = 22,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned NEAR_THRESH    = 55000,
  parameter int unsigned HYST           = 2000,
  parameter int unsigned GAP_CYCLES     = 3000000
) (
  input  logic                fpgaclk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] echo,
  output logic [CHANNELS-1:0] trigger,
  output logic [CHANNELS-1:0] obstacle,
  output logic [WIDTH-1:0]    width_out,
  output logic [2:0]          width_ch,
  output logic                width_valid,
  output logic                timeout_err
);

  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // One counter serves trigger, echo and gap timing, so it must hold the longest interval.
  localparam int unsigned CntW = (WIDTH > 32) ? WIDTH : 32;

  localparam logic [CntW-1:0]  TrigLast   = CntW'(TRIG_CYCLES - 1);
  localparam logic [CntW-1:0]  TimeoutCnt = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0]  GapLast    = CntW'(GAP_CYCLES - 1);
  localparam logic [WIDTH-1:0] TimeoutW   = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] NearW      = WIDTH'(NEAR_THRESH);
  localparam logic [WIDTH-1:0] ReleaseW   = WIDTH'(NEAR_THRESH + HYST);
  localparam logic [ChW-1:0]   ChLast     = ChW'(CHANNELS - 1);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StGap} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [CHANNELS-1:0] echo_s1_q, echo_s2_q;
  logic [CHANNELS-1:0] trigger_q, trigger_d;
  logic [CHANNELS-1:0] obstacle_q, obstacle_d;
  logic [WIDTH-1:0]    width_q, width_d;
  logic [2:0]          width_ch_q, width_ch_d;
  logic                valid_q, valid_d;
  logic                terr_q, terr_d;
  logic                echo_cur, meas_done, meas_to;

  assign cnt_inc  = cnt_q + CntW'(1);
  assign echo_cur = echo_s2_q[ch_q];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    obstacle_d = obstacle_q;
    width_d    = width_q;
    width_ch_d = width_ch_q;
    valid_d    = 1'b0;
    terr_d     = 1'b0;
    meas_done  = 1'b0;
    meas_to    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StTrig;
          cnt_d   = '0;
        end
      end
      StTrig: begin
        if (cnt_q == TrigLast) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitRise: begin
        if (echo_cur) begin
          state_d = StMeasure;
          cnt_d   = CntW'(1);
        end else if (cnt_inc == TimeoutCnt) begin
          meas_done = 1'b1;
          meas_to   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StMeasure: begin
        if (!echo_cur) begin
          meas_done = 1'b1;
        end else if (cnt_q == TimeoutCnt) begin
          meas_done = 1'b1;
          meas_to   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          ch_d    = (ch_q == ChLast) ? '0 : ch_q + ChW'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    // Result publication happens on the transition into the gap.
    if (meas_done) begin
      state_d    = StGap;
      cnt_d      = '0;
      valid_d    = 1'b1;
      terr_d     = meas_to;
      width_d    = meas_to ? TimeoutW : WIDTH'(cnt_q);
      width_ch_d = 3'(ch_q);
      if (meas_to) begin
        obstacle_d[ch_q] = 1'b0;
      end else if (width_d < NearW) begin
        obstacle_d[ch_q] = 1'b1;
      end else if (width_d >= ReleaseW) begin
        obstacle_d[ch_q] = 1'b0;
      end
    end

    trigger_d = (state_d == StTrig) ? (CHANNELS'(1) << ch_q) : '0;
  end

  always_ff @(posedge fpgaclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ch_q       <= '0;
      echo_s1_q  <= '0;
      echo_s2_q  <= '0;
      trigger_q  <= '0;
      obstacle_q <= '0;
      width_q    <= '0;
      width_ch_q <= '0;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      echo_s1_q  <= echo;
      echo_s2_q  <= echo_s1_q;
      trigger_q  <= trigger_d;
      obstacle_q <= obstacle_d;
      width_q    <= width_d;
      width_ch_q <= width_ch_d;
      valid_q    <= valid_d;
      terr_q     <= terr_d;
    end
  end

  assign trigger     = trigger_q;
  assign obstacle    = obstacle_q;
  assign width_out   = width_q;
  assign width_ch    = width_ch_q;
  assign width_valid = valid_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: table of per-measurement vectors applied round-robin,
// plus reset-during-measure and enable-drop sequences.
module tb_ultrasonic_ranger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  echo = '0;
  logic [1:0]  trigger, obstacle;
  logic [21:0] width_out;
  logic [2:0]  width_ch;
  logic        width_valid, timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int got, cap_w, cap_ch, cap_obst, cap_terr, cap_lat, cap_cyc, trig_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ultrasonic_ranger #(
    .CHANNELS      (2),
    .WIDTH         (22),
    .TRIG_CYCLES   (4),
    .TIMEOUT_CYCLES(100),
    .NEAR_THRESH   (20),
    .HYST          (5),
    .GAP_CYCLES    (8)
  ) dut (
    .fpgaclk    (clk),
    .reset_n    (rst_n),
    .enable     (en),
    .echo       (echo),
    .trigger    (trigger),
    .obstacle   (obstacle),
    .width_out  (width_out),
    .width_ch   (width_ch),
    .width_valid(width_valid),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int ch;
    int delay;     // cycles after trigger falls before echo rises
    int hi;        // raw echo high time; 0 = no echo
    int exp_w;
    int exp_obst;
    int exp_terr;
    int exp_lat;   // cycles from trigger fall to width_valid; -1 = not checked
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_trigger"}, int'(trigger), 0);
    chk({tag, "_obstacle"}, int'(obstacle), 0);
    chk({tag, "_width_out"}, int'(width_out), 0);
    chk({tag, "_width_ch"}, int'(width_ch), 0);
    chk({tag, "_width_valid"}, int'(width_valid), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  // Called at a negedge; returns at the first negedge with trigger low again.
  task automatic wait_trig(input int ch, output int len);
    int n;
    n = 0;
    len = 0;
    while (trigger == 2'b00 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("trig_onehot", int'(trigger), 1 << ch);
    trig_cyc = cyc;
    while (trigger != 2'b00 && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Drives echo[ch] high for hi cycles starting delay cycles in, and captures the result strobe.
  task automatic run_echo(input int ch, input int delay, input int hi, input int drop_at);
    got = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      @(posedge clk);
      #1;
      echo[ch] = (c >= delay && c < delay + hi);
      if (c == drop_at) en = 1'b0;
      @(negedge clk);
      if (width_valid) begin
        got      = 1;
        cap_w    = int'(width_out);
        cap_ch   = int'(width_ch);
        cap_obst = int'(obstacle);
        cap_terr = int'(timeout_err);
        cap_lat  = c + 1;
        cap_cyc  = cyc;
      end
    end
    echo = '0;
    chk("valid_seen", got, 1);
    @(negedge clk);
    chk("valid_one_cycle", int'(width_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, stale, n, trig_seen, valid_seen;

    vecs[0]  = '{0, 3, 15,  15,  1, 0, 22};
    vecs[1]  = '{1, 2, 22,  22,  1, 0, 28};
    vecs[2]  = '{0, 1, 22,  22,  1, 0, 27};
    vecs[3]  = '{1, 0, 10,  10,  3, 0, 14};
    vecs[4]  = '{0, 4, 24,  24,  3, 0, 32};
    vecs[5]  = '{1, 0, 0,   100, 1, 1, 100};
    vecs[6]  = '{0, 2, 25,  25,  0, 0, 31};
    vecs[7]  = '{1, 1, 5,   5,   2, 0, 10};
    vecs[8]  = '{0, 0, 19,  19,  3, 0, 23};
    vecs[9]  = '{1, 0, 200, 100, 1, 1, -1};
    vecs[10] = '{0, 5, 99,  99,  0, 0, 108};
    vecs[11] = '{1, 3, 1,   1,   2, 0, 8};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_disabled_trigger", int'(trigger), 0);
    en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      wait_trig(vecs[i].ch, len);
      chk("trig_len", len, 4);
      if (i > 0) chk("rr_gap_to_trigger", trig_cyc - cap_cyc, 9);
      run_echo(vecs[i].ch, vecs[i].delay, vecs[i].hi, -1);
      chk("width_out", cap_w, vecs[i].exp_w);
      chk("width_ch", cap_ch, vecs[i].ch);
      chk("obstacle", cap_obst, vecs[i].exp_obst);
      chk("timeout_err", cap_terr, vecs[i].exp_terr);
      if (vecs[i].exp_lat >= 0) chk("strobe_latency", cap_lat, vecs[i].exp_lat);
    end

    // Reset in the middle of a ch1 measurement, with obstacle bits set beforehand.
    wait_trig(0, len);
    run_echo(0, 1, 15, -1);
    chk("pre_reset_obstacle", cap_obst, 3);
    wait_trig(1, len);
    repeat (2) @(posedge clk);
    #1 echo[1] = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    echo = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    n = 0;
    while (trigger == 2'b00 && n < 50) begin
      @(negedge clk);
      if (width_valid) stale++;
      n++;
    end
    chk("no_stale_strobe", stale, 0);
    wait_trig(0, len);
    chk("post_reset_trig_len", len, 4);
    run_echo(0, 2, 10, -1);
    chk("post_reset_width", cap_w, 10);
    chk("post_reset_ch", cap_ch, 0);
    chk("post_reset_obstacle", cap_obst, 1);

    // Enable dropped during MEASURE: result still reported, then the FSM parks in IDLE.
    wait_trig(1, len);
    run_echo(1, 2, 12, 8);
    chk("en_drop_width", cap_w, 12);
    chk("en_drop_ch", cap_ch, 1);
    chk("en_drop_obstacle", cap_obst, 3);
    chk("en_drop_terr", cap_terr, 0);
    trig_seen = 0;
    valid_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (trigger != 2'b00) trig_seen++;
      if (width_valid) valid_seen++;
    end
    chk("en_drop_no_trigger", trig_seen, 0);
    chk("en_drop_no_strobe", valid_seen, 0);
    en = 1'b1;
    wait_trig(0, len);
    chk("resume_trig_len", len, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Parametrised multi-channel ultrasonic ranging controller. It fires HC-SR04-style sensors one channel at a time in round-robin order and measures each echo pulse width in clock cycles. It applies a near-obstacle threshold with hysteresis per channel and flags missing or over-long echoes as timeouts. It sits between the sensor pins and the obstacle-avoidance logic, and supersedes the single-channel fixed-threshold detector.

## Interface
- CHANNELS, 2: number of sensors (1..8)
- WIDTH, 22: pulse-width counter width
- TRIG_CYCLES, 500: trigger high time in cycles (10 µs at 50 MHz)
- TIMEOUT_CYCLES, 1900000: maximum wait for echo rise, and maximum echo width
- NEAR_THRESH, 55000: obstacle asserted when width < NEAR_THRESH
- HYST, 2000: obstacle released when width >= NEAR_THRESH + HYST
- GAP_CYCLES, 3000000: quiet time after each measurement before the next channel fires
- fpgaclk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run ranging; sampled only in IDLE
- echo  in  CHANNELS  raw sensor echo inputs, asynchronous
- trigger  out  CHANNELS  sensor trigger outputs, registered, one-hot or zero
- obstacle  out  CHANNELS  per-channel near-obstacle flag
- width_out  out  WIDTH  last measured width
- width_ch  out  3  channel index of width_out
- width_valid  out  1  one-cycle strobe for width_out and width_ch
- timeout_err  out  1  one-cycle strobe, concurrent with width_valid, when the measurement timed out

## Operation
- Each echo bit passes through a 2-flop synchroniser. All FSM decisions use the synchronised value.
- State IDLE:
  - If enable=1, clear the counter and go to TRIG.
- State TRIG:
  - trigger[ch]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with the counter cleared.
- State WAIT_RISE:
  - Counter increments each cycle.
  - Synchronised echo[ch]=1: clear the counter to 1 and go to MEASURE.
  - Counter reaches TIMEOUT_CYCLES: record a timeout and go to GAP.
- State MEASURE:
  - Counter increments while synchronised echo[ch]=1.
  - First low sample: go to GAP with width = counter value.
  - Counter reaches TIMEOUT_CYCLES while echo is still high: record a timeout, width = TIMEOUT_CYCLES (saturated), go to GAP.
- Entering GAP:
  - width_out, width_ch and obstacle[ch] update.
  - width_valid pulses for one cycle, together with timeout_err if a timeout was recorded.
- Obstacle update for channel ch, non-timeout:
  - width < NEAR_THRESH: set to 1.
  - width >= NEAR_THRESH+HYST: set to 0.
  - Otherwise: hold.
- Obstacle update on timeout: force obstacle[ch]=0.
- Other channels' obstacle bits never change during a measurement of ch.
- State GAP:
  - Counts GAP_CYCLES.
  - Then ch = (ch==CHANNELS-1) ? 0 : ch+1, and go to IDLE.
- enable=0 mid-measurement: the current measurement and its GAP complete normally; the FSM then waits in IDLE.
- The echo of any channel other than ch is ignored.
- Arithmetic: comparisons are unsigned in WIDTH bits. NEAR_THRESH+HYST must fit in WIDTH; the counter never wraps.

## Timing
- Reset (async assert, sync release) forces the following until the first clock after deassertion:
  - Outputs: trigger=0, obstacle=0, width_out=0, width_ch=0, width_valid=0, timeout_err=0.
  - Internal state: FSM in IDLE, ch=0, synchronisers cleared.
- Reset mid-operation:
  - Trigger drops immediately.
  - Any measurement in progress is discarded; no strobe is issued.
- Trigger rises on the cycle after IDLE samples enable=1.
- Echo latency: an edge on echo is seen by the FSM 2 cycles later. Reported width equals the raw echo high time in cycles, independent of that latency.
- The width_valid cycle is the first GAP cycle: 1 cycle after the first low synchronised sample, or after the timeout count.
- Measurement period per channel = 1 + TRIG_CYCLES + wait + width + GAP_CYCLES cycles.

## Test plan
Params for all directed tests: CHANNELS=2, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, NEAR_THRESH=20, HYST=5, GAP_CYCLES=8.
- Basic near detection: enable=1; echo[0] goes high 3 cycles after trigger[0] falls and stays high 15 cycles -> trigger[0] high 4 cycles; width_valid with width_out=15, width_ch=0, obstacle[0]=1, timeout_err=0.
- Hysteresis on ch0: starting with obstacle[0]=1 from a width of 15, apply successive widths 22, 24, 25.
  - Width 22: obstacle[0] stays 1.
  - Width 24: obstacle[0] stays 1.
  - Width 25: obstacle[0]=0.
  - Then width 19: obstacle[0]=1.
- Round-robin: two back-to-back measurements -> trigger[1] fires only after ch0's 8-cycle gap; width_ch=1; obstacle[0] is unchanged by the ch1 result; the third measurement returns to ch0.
- Timeouts:
  - No echo: width_valid and timeout_err pulse together 100 cycles after the trigger falls; obstacle[ch]=0.
  - Echo stuck high: width_out=100, timeout_err=1.
- Reset and enable control:
  - Assert reset_n=0 during MEASURE: all outputs go to 0 asynchronously; after release, the first trigger is on ch0 and no stale strobe appears.
  - Drop enable mid-MEASURE: the result is still reported, and no further trigger occurs.
